// File: rtl/mod_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod_addsub_ctrl
// Purpose  : (a+b) mod m / (a-b) mod m sequencer driving the shared multi-cycle
//            adder twice: raw add/sub, then correction by m.
//            Build option MODADD_CONST_TIME_EN: subtract always runs phase 2.
// Revision : 1.0 - initial release
// ============================================================================
module mod_addsub_ctrl #(
  parameter int W = 514
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_c,
  input  logic         add_done
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_P1_GO   = 3'd1;
  localparam logic [2:0] c_P1_WAIT = 3'd2;
  localparam logic [2:0] c_P2_GO   = 3'd3;
  localparam logic [2:0] c_P2_WAIT = 3'd4;
  localparam logic [2:0] c_FIN     = 3'd5;

`ifdef MODADD_CONST_TIME_EN
  localparam logic c_CONST_TIME = 1'b1;
`else
  localparam logic c_CONST_TIME = 1'b0;
`endif

  logic [2:0]   r_state;
  logic [W-1:0] r_m;
  logic         r_op;
  logic [W-1:0] r_sum;

  // Subtract without borrow is already reduced; only the constant-time build
  // keeps going, and then it adds zero so the answer is unchanged.
  logic w_p1Final;
  assign w_p1Final = r_op & ~add_c[W];

  // Operands are latched straight into add_a/add_b on accept so the adder
  // sees add_start in the first cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_m          <= '0;
      r_op         <= 1'b0;
      r_sum        <= '0;
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_m          <= m;
            r_op         <= op_sub;
            add_a        <= a;
            add_b        <= b;
            add_subtract <= op_sub;
            add_start    <= 1'b1;
            busy         <= 1'b1;
            r_state      <= c_P1_GO;
          end
        end
        c_P1_GO: begin
          add_start <= 1'b0;
          r_state   <= c_P1_WAIT;
        end
        c_P1_WAIT: begin
          if (add_done) begin
            r_sum <= add_c[W-1:0];
            if (w_p1Final && !c_CONST_TIME) begin
              result  <= add_c[W-1:0];
              done    <= 1'b1;
              r_state <= c_FIN;
            end else begin
              add_a        <= add_c[W-1:0];
              add_b        <= w_p1Final ? '0 : r_m;
              add_subtract <= ~r_op;
              add_start    <= 1'b1;
              r_state      <= c_P2_GO;
            end
          end
        end
        c_P2_GO: begin
          add_start <= 1'b0;
          r_state   <= c_P2_WAIT;
        end
        c_P2_WAIT: begin
          if (add_done) begin
            // For add, a borrow from (s - m) means s was already below m.
            result  <= (!r_op && add_c[W]) ? r_sum : add_c[W-1:0];
            done    <= 1'b1;
            r_state <= c_FIN;
          end
        end
        c_FIN: begin
          busy    <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          add_start <= 1'b0;
          busy      <= 1'b0;
          r_state   <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_ctrl.sv
`default_nettype none
// Bench for mod_addsub_ctrl: behavioural adder responder plus modular-arithmetic
// reference model, directed cases followed by random operands.
module tb_mod_addsub_ctrl;
  localparam int W = 514;
  localparam int c_ADD_LAT = 6;

`ifdef MODADD_CONST_TIME_EN
  localparam bit c_CONST_TIME = 1'b1;
`else
  localparam bit c_CONST_TIME = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, m = '0;
  logic [W-1:0] result;
  logic         done, busy, add_start, add_subtract;
  logic [W-1:0] add_a, add_b;
  logic [W:0]   add_c = '0;
  logic         add_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acceptCyc = 0;
  int doneCnt = 0;
  int asQ[$];

  mod_addsub_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .m(m), .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_done(add_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stand-in: samples operands in its start cycle, answers 6 cycles later.
  int           aCnt = 0;
  logic [W-1:0] aOpA, aOpB;
  logic         aSub;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (rst) begin
      aCnt  <= 0;
      add_c <= '0;
    end else if (add_start) begin
      aOpA <= add_a;
      aOpB <= add_b;
      aSub <= add_subtract;
      aCnt <= c_ADD_LAT - 1;
    end else if (aCnt == 1) begin
      add_c    <= aSub ? ({1'b0, aOpA} - {1'b0, aOpB}) : ({1'b0, aOpA} + {1'b0, aOpB});
      add_done <= 1'b1;
      aCnt     <= 0;
    end else if (aCnt > 1) begin
      aCnt <= aCnt - 1;
    end
  end

  always @(negedge clk) begin
    if (add_start) asQ.push_back(cyc - acceptCyc);
    if (done) doneCnt++;
  end

  function automatic logic [W-1:0] refMod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] md, input logic sub);
    logic [W+1:0] t;
    if (sub) t = ({2'b00, x} + {2'b00, md} - {2'b00, y}) % {2'b00, md};
    else     t = ({2'b00, x} + {2'b00, y}) % {2'b00, md};
    return t[W-1:0];
  endfunction

  function automatic int refLat(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    return (sub && x >= y && !c_CONST_TIME) ? 8 : 15;
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start in cycle 0; returns at the negedge of cycle 1.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] md, input logic sub);
    @(negedge clk);
    a = x; b = y; m = md; op_sub = sub; start = 1'b1;
    acceptCyc = cyc;
    asQ.delete();
    doneCnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishCheck(input string tag, input logic [W-1:0] expRes, input int expLat);
    int n;
    while (done !== 1'b1 && (cyc - acceptCyc) < 60) @(negedge clk);
    n = cyc - acceptCyc;
    check({tag, " latency"}, n, expLat);
    check({tag, " result"}, {1'b0, result}, {1'b0, expRes});
    check({tag, " busy@done"}, busy, 1'b1);
    check({tag, " starts"}, asQ.size(), (expLat == 15) ? 2 : 1);
    if (asQ.size() > 0) check({tag, " start1 cyc"}, asQ[0], 1);
    if (asQ.size() > 1) check({tag, " start2 cyc"}, asQ[1], 8);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " busy end"}, busy, 1'b0);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] md, input logic sub);
    launch(x, y, md, sub);
    finishCheck(tag, refMod(x, y, md, sub), refLat(x, y, sub));
  endtask

  initial begin
    logic [W-1:0] bigM, ra, rb, rm, mask;
    int nb;
    repeat (3) @(negedge clk);
    check("rst result", {1'b0, result}, '0);
    check("rst done", done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst add_start", add_start, 1'b0);
    check("rst add_sub", add_subtract, 1'b0);
    check("rst add_a", {1'b0, add_a}, '0);
    check("rst add_b", {1'b0, add_b}, '0);
    rst = 1'b0;

    launch(514'd5, 514'd7, 514'd11, 1'b0);
    finishCheck("add 5+7", 514'd1, 15);
    launch(514'd2, 514'd3, 514'd11, 1'b0);
    finishCheck("add 2+3", 514'd5, 15);
    launch(514'd9, 514'd4, 514'd11, 1'b1);
    finishCheck("sub 9-4", 514'd5, c_CONST_TIME ? 15 : 8);
    launch(514'd4, 514'd9, 514'd11, 1'b1);
    finishCheck("sub 4-9", 514'd6, 15);

    bigM = (514'd1 << 513) - 514'd1;
    launch(bigM - 514'd1, bigM - 514'd1, bigM, 1'b0);
    finishCheck("add wrap", (514'd1 << 513) - 514'd3, 15);

    // Second start mid-operation must be ignored.
    launch(514'd5, 514'd7, 514'd11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 514'd1; b = 514'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finishCheck("stray start", 514'd1, 15);
    repeat (20) @(negedge clk);
    check("stray single done", doneCnt, 1);
    check("stray idle", busy, 1'b0);

    // Reset mid-operation.
    launch(514'd3, 514'd4, 514'd11, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst no done", doneCnt, 0);
    launch(514'd1, 514'd1, 514'd11, 1'b0);
    finishCheck("after rst", 514'd2, 15);

    for (int i = 0; i < 16; i++) begin
      nb = $urandom_range(4, W - 1);
      mask = {W{1'b1}} >> (W - nb);
      rm = (randWide() & mask) | 514'd2;
      ra = randWide() % rm;
      rb = randWide() % rm;
      runOp($sformatf("rand%0d", i), ra, rb, rm, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
